// File: rtl/up_down_counter_n.sv
// up_down_counter_n: parametrised synchronous up/down counter.
// Features: configurable width and modulus (0..MAX), count enable,
// synchronous parallel load with clamp to MAX, combinational terminal
// count and registered one-cycle wrap indicators.
// Optional build macro: UP_DOWN_COUNTER_N_SATURATE_EN
//   undefined -> count wraps at the bounds (MAX->0 going up, 0->MAX going down)
//   defined   -> count saturates at the bounds (holds MAX / holds 0)
// In both builds wrap_up / wrap_dn pulse on every boundary event.
module up_down_counter_n #(
  parameter int unsigned          WIDTH   = 8,
  parameter logic [WIDTH-1:0]     MAX     = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]     RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap_up,
  output logic             wrap_dn
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Value taken when a count runs into a bound. Wrap mode jumps to the
  // opposite bound; saturate mode stays put. Binary rollover is never
  // used, so MAX below 2**WIDTH-1 behaves the same as a full-range counter.
`ifdef UP_DOWN_COUNTER_N_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_BOUND_NEXT = MAX;
  localparam logic [WIDTH-1:0] DN_BOUND_NEXT = ZERO;
`else
  localparam logic [WIDTH-1:0] UP_BOUND_NEXT = ZERO;
  localparam logic [WIDTH-1:0] DN_BOUND_NEXT = MAX;
`endif

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             wrap_up_q;
  logic             wrap_up_d;
  logic             wrap_dn_q;
  logic             wrap_dn_d;
  logic             at_max_s;
  logic             at_zero_s;
  logic [WIDTH-1:0] load_clamped_s;

  assign at_max_s       = (q_q == MAX);
  assign at_zero_s      = (q_q == ZERO);
  assign load_clamped_s = (load_val > MAX) ? MAX : load_val;

  // Next-state: load beats count beats hold; wrap flags only set on a bound hit.
  always_comb begin
    q_d       = q_q;
    wrap_up_d = 1'b0;
    wrap_dn_d = 1'b0;
    if (load) begin
      q_d = load_clamped_s;
    end else if (en) begin
      if (mode) begin
        if (at_max_s) begin
          q_d       = UP_BOUND_NEXT;
          wrap_up_d = 1'b1;
        end else begin
          q_d = q_q + ONE;
        end
      end else begin
        if (at_zero_s) begin
          q_d       = DN_BOUND_NEXT;
          wrap_dn_d = 1'b1;
        end else begin
          q_d = q_q - ONE;
        end
      end
    end else begin
      q_d = q_q;
    end
  end

  // State register with synchronous reset overriding load/count.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= RST_VAL;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      wrap_up_q <= wrap_up_d;
      wrap_dn_q <= wrap_dn_d;
    end
  end

  // Terminal count looks at the bound the current direction is heading for;
  // it ignores en so it can gate the enable of a following stage.
  assign tc      = mode ? at_max_s : at_zero_s;
  assign q       = q_q;
  assign wrap_up = wrap_up_q;
  assign wrap_dn = wrap_dn_q;

endmodule

// File: tb/tb_up_down_counter_n.sv
// Self-checking bench for up_down_counter_n (WIDTH=4, MAX=9, RST_VAL=0).
// The reference model counts with plain integers and the bound rules.
module tb_up_down_counter_n;

  localparam int MAXV = 9;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc;
  logic       wrap_up;
  logic       wrap_dn;

  // cascade pair
  logic       c_rst;
  logic       c_en;
  logic       t_en;
  logic [3:0] u_q;
  logic [3:0] t_q;
  logic       u_tc;
  logic       t_tc;
  logic       u_wu;
  logic       u_wd;
  logic       t_wu;
  logic       t_wd;

  int  n_tests;
  int  n_fail;
  int  m_q;
  bit  m_wu;
  bit  m_wd;

  up_down_counter_n #(.WIDTH(4), .MAX(4'd9), .RST_VAL(4'd0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .q(q), .tc(tc), .wrap_up(wrap_up), .wrap_dn(wrap_dn)
  );

  up_down_counter_n #(.WIDTH(4), .MAX(4'd9), .RST_VAL(4'd0)) u_units (
    .clk(clk), .rst(c_rst), .en(c_en), .mode(1'b1), .load(1'b0),
    .load_val(4'd0), .q(u_q), .tc(u_tc), .wrap_up(u_wu), .wrap_dn(u_wd)
  );

  assign t_en = c_en & u_tc;

  up_down_counter_n #(.WIDTH(4), .MAX(4'd9), .RST_VAL(4'd0)) u_tens (
    .clk(clk), .rst(c_rst), .en(t_en), .mode(1'b1), .load(1'b0),
    .load_val(4'd0), .q(t_q), .tc(t_tc), .wrap_up(t_wu), .wrap_dn(t_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit sat_build();
`ifdef UP_DOWN_COUNTER_N_SATURATE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_tc();
    return (mode && m_q == MAXV) || (!mode && m_q == 0);
  endfunction

  task automatic set_in(input logic r, input logic l, input logic e,
                        input logic md, input logic [3:0] lv);
    rst = r; load = l; en = e; mode = md; load_val = lv;
    #1;
  endtask

  // Advance the model by the spec rules using current inputs, then clock.
  task automatic tick();
    int nxt;
    m_wu = 1'b0;
    m_wd = 1'b0;
    if (rst) begin
      m_q = 0;
    end else if (load) begin
      m_q = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
    end else if (en) begin
      nxt = mode ? m_q + 1 : m_q - 1;
      if (nxt > MAXV) begin
        m_wu = 1'b1;
        m_q  = sat_build() ? MAXV : 0;
      end else if (nxt < 0) begin
        m_wd = 1'b1;
        m_q  = sat_build() ? 0 : MAXV;
      end else begin
        m_q = nxt;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    tick();
    tick();
    n_tests++;
    if (q !== 4'd0) begin
      n_fail++; $display("FAIL reset_q: got %0d want 0", q);
    end
    n_tests++;
    if (wrap_up !== 1'b0 || wrap_dn !== 1'b0) begin
      n_fail++; $display("FAIL reset_wrap: got %b%b want 00", wrap_up, wrap_dn);
    end
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    n_tests++;
    if (q !== 4'd1) begin
      n_fail++; $display("FAIL reset_release: got %0d want 1", q);
    end
  endtask

  task automatic test_up_wrap();
    int pulses;
    pulses = 0;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    for (int i = 0; i < 12; i++) begin
      set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      n_tests++;
      if (tc !== exp_tc()) begin
        n_fail++; $display("FAIL up_tc[%0d]: got %b want %b", i, tc, exp_tc());
      end
      tick();
      n_tests++;
      if (q !== m_q[3:0] || wrap_up !== m_wu || wrap_dn !== m_wd) begin
        n_fail++;
        $display("FAIL up_wrap[%0d]: got q=%0d wu=%b wd=%b want q=%0d wu=%b wd=%b",
                 i, q, wrap_up, wrap_dn, m_q, m_wu, m_wd);
      end
      if (wrap_up === 1'b1) pulses++;
    end
    n_tests++;
    if (q !== (sat_build() ? 4'd9 : 4'd2) || pulses != (sat_build() ? 3 : 1)) begin
      n_fail++;
      $display("FAIL up_final: got q=%0d pulses=%0d want q=%0d pulses=%0d",
               q, pulses, sat_build() ? 9 : 2, sat_build() ? 3 : 1);
    end
  endtask

  task automatic test_down_wrap();
    int pulses;
    pulses = 0;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
    tick();
    n_tests++;
    if (q !== 4'd2) begin
      n_fail++; $display("FAIL down_load: got %0d want 2", q);
    end
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      n_tests++;
      if (tc !== exp_tc()) begin
        n_fail++; $display("FAIL down_tc[%0d]: got %b want %b", i, tc, exp_tc());
      end
      tick();
      n_tests++;
      if (q !== m_q[3:0] || wrap_up !== m_wu || wrap_dn !== m_wd) begin
        n_fail++;
        $display("FAIL down_wrap[%0d]: got q=%0d wu=%b wd=%b want q=%0d wu=%b wd=%b",
                 i, q, wrap_up, wrap_dn, m_q, m_wu, m_wd);
      end
      if (wrap_dn === 1'b1) pulses++;
    end
    n_tests++;
    if (q !== (sat_build() ? 4'd0 : 4'd8) || pulses != (sat_build() ? 2 : 1)) begin
      n_fail++;
      $display("FAIL down_final: got q=%0d pulses=%0d want q=%0d pulses=%0d",
               q, pulses, sat_build() ? 0 : 8, sat_build() ? 2 : 1);
    end
  endtask

  task automatic test_load_clamp();
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 4'd15);
    tick();
    n_tests++;
    if (q !== 4'd9 || wrap_up !== 1'b0 || wrap_dn !== 1'b0) begin
      n_fail++;
      $display("FAIL load_clamp: got q=%0d wu=%b wd=%b want q=9 wu=0 wd=0",
               q, wrap_up, wrap_dn);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
      tick();
      n_tests++;
      if (q !== 4'd9 || wrap_up !== 1'b0) begin
        n_fail++; $display("FAIL load_hold[%0d]: got q=%0d wu=%b want q=9 wu=0", i, q, wrap_up);
      end
    end
  endtask

  task automatic test_dir_change();
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    n_tests++;
    if (tc !== 1'b0) begin
      n_fail++; $display("FAIL dir_tc_at9_down: got %b want 0", tc);
    end
    tick();
    n_tests++;
    if (q !== 4'd8 || wrap_up !== 1'b0 || wrap_dn !== 1'b0) begin
      n_fail++; $display("FAIL dir_9_down: got q=%0d wu=%b wd=%b want 8 0 0", q, wrap_up, wrap_dn);
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    n_tests++;
    if (q !== 4'd1 || wrap_up !== 1'b0 || wrap_dn !== 1'b0) begin
      n_fail++; $display("FAIL dir_0_up: got q=%0d wu=%b wd=%b want 1 0 0", q, wrap_up, wrap_dn);
    end
  endtask

  task automatic test_random();
    logic r, l, e, md;
    logic [3:0] lv;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      md = $urandom_range(0, 1);
      lv = 4'($urandom_range(0, 15));
      set_in(r, l, e, md, lv);
      n_tests++;
      if (tc !== exp_tc()) begin
        n_fail++; $display("FAIL rand_tc[%0d]: got %b want %b", i, tc, exp_tc());
      end
      tick();
      n_tests++;
      if (q !== m_q[3:0] || wrap_up !== m_wu || wrap_dn !== m_wd) begin
        n_fail++;
        $display("FAIL rand[%0d]: got q=%0d wu=%b wd=%b want q=%0d wu=%b wd=%b",
                 i, q, wrap_up, wrap_dn, m_q, m_wu, m_wd);
      end
    end
  endtask

  task automatic test_cascade();
    int tens_pulses;
    int exp_u;
    int exp_t;
    tens_pulses = 0;
    c_rst = 1'b1; c_en = 1'b0;
    @(posedge clk); #1;
    c_rst = 1'b0; c_en = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (sat_build()) begin
        exp_u = (k > 9) ? 9 : k;
        exp_t = (k - 9 < 0) ? 0 : ((k - 9 > 9) ? 9 : k - 9);
      end else begin
        exp_u = (k % 100) % 10;
        exp_t = (k % 100) / 10;
      end
      n_tests++;
      if (u_q !== exp_u[3:0] || t_q !== exp_t[3:0]) begin
        n_fail++;
        $display("FAIL cascade[%0d]: got %0d:%0d want %0d:%0d", k, t_q, u_q, exp_t, exp_u);
      end
      if (!sat_build()) begin
        if (t_wu === 1'b1) begin
          tens_pulses++;
          n_tests++;
          if (u_wu !== 1'b1 || k != 100) begin
            n_fail++;
            $display("FAIL cascade_coincide[%0d]: got units_wu=%b want 1 at k=100", k, u_wu);
          end
        end
      end
    end
    c_en = 1'b0;
    if (!sat_build()) begin
      n_tests++;
      if (tens_pulses != 1) begin
        n_fail++; $display("FAIL cascade_pulses: got %0d want 1", tens_pulses);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m_q = 0; m_wu = 1'b0; m_wd = 1'b0;
    rst = 1'b1; en = 1'b0; mode = 1'b1; load = 1'b0; load_val = 4'd0;
    c_rst = 1'b1; c_en = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_dir_change();
    test_random();
    test_cascade();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
